// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / stall controller.
// Holds the mul/div wait FSM encoding and the control-bundle layout.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam int unsigned MD_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic idex_bub;
    logic exmem_bub;
    logic ifid_flush;
    logic md_start;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = pipeline side, slave = controller side.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IF_ID_RegisterRs1;
  logic [4:0]       IF_ID_RegisterRs2;
  logic             IF_ID_UsesRs1;
  logic             IF_ID_UsesRs2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegisterRd;
  logic             ID_EX_IsMulDiv;
  logic             md_done;
  logic             branch_taken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             ID_EX_Bubble;
  logic             EX_MEM_Bubble;
  logic             IF_ID_Flush;
  logic             md_start;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2,
    output IF_ID_UsesRs1, IF_ID_UsesRs2,
    output ID_EX_MemRead, ID_EX_RegisterRd,
    output ID_EX_IsMulDiv, md_done, branch_taken,
    input  PCWrite, IF_ID_Write, ID_EX_Write,
    input  ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush,
    input  md_start, md_timeout, stall_cycles
  );

  modport slave (
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2,
    input  IF_ID_UsesRs1, IF_ID_UsesRs2,
    input  ID_EX_MemRead, ID_EX_RegisterRd,
    input  ID_EX_IsMulDiv, md_done, branch_taken,
    output PCWrite, IF_ID_Write, ID_EX_Write,
    output ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush,
    output md_start, md_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used to count pipeline stall cycles.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Advance only while enabled and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall control: mul/div freeze, branch flush,
// load-use stall, timeout watchdog and stall-cycle statistics.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  hazard_stall_ctrl_if.slave hz
);

  localparam int unsigned WW = $clog2(MD_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(MD_TIMEOUT);

  md_state_e     state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          tmo_q, tmo_d;
  hz_ctrl_t      ctl;
  logic          lu_hit;
  logic          frz;
  logic          redir;
  logic          lus;
  logic          in_run;

  assign in_run = (state_q == RUN);

  assign lu_hit = hz.ID_EX_MemRead
    && (hz.ID_EX_RegisterRd != 5'd0)
    && ((hz.IF_ID_UsesRs1
         && hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs1)
     || (hz.IF_ID_UsesRs2
         && hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs2));

  // Mutually exclusive actions in priority order.
  assign frz = in_run ? hz.ID_EX_IsMulDiv : !hz.md_done;
  assign redir = in_run && !hz.ID_EX_IsMulDiv
    && hz.branch_taken;
  assign lus = in_run && !hz.ID_EX_IsMulDiv
    && !hz.branch_taken && lu_hit;

  // Next state, wait counter and sticky timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      RUN: begin
        if (hz.ID_EX_IsMulDiv) begin
          state_d = MD_WAIT;
          wait_d  = '0;
        end
      end
      MD_WAIT: begin
        if (hz.md_done) begin
          state_d = RUN;
        end else if (wait_q != TO_VAL) begin
          wait_d = wait_q + 1'b1;
          if (wait_d == TO_VAL) tmo_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipeline control decode; release cycle is normal flow.
  always_comb begin
    ctl         = '0;
    ctl.pc_we   = 1'b1;
    ctl.ifid_we = 1'b1;
    ctl.idex_we = 1'b1;
    unique case (1'b1)
      frz: begin
        ctl.pc_we     = 1'b0;
        ctl.ifid_we   = 1'b0;
        ctl.idex_we   = 1'b0;
        ctl.exmem_bub = 1'b1;
        ctl.md_start  = in_run;
      end
      redir: begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_bub   = 1'b1;
      end
      lus: begin
        ctl.pc_we    = 1'b0;
        ctl.ifid_we  = 1'b0;
        ctl.idex_bub = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM, wait counter and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!ctl.pc_we),
    .cnt_o (hz.stall_cycles)
  );

  assign hz.PCWrite       = ctl.pc_we      & rst_n;
  assign hz.IF_ID_Write   = ctl.ifid_we    & rst_n;
  assign hz.ID_EX_Write   = ctl.idex_we    & rst_n;
  assign hz.ID_EX_Bubble  = ctl.idex_bub   & rst_n;
  assign hz.EX_MEM_Bubble = ctl.exmem_bub  & rst_n;
  assign hz.IF_ID_Flush   = ctl.ifid_flush & rst_n;
  assign hz.md_start      = ctl.md_start   & rst_n;
  assign hz.md_timeout    = tmo_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int CW   = 16;
  localparam int MDTO = 64;
  localparam longint SATMAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_stall_ctrl #(
    .MD_TIMEOUT (MDTO),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  typedef struct packed {
    bit pc, ifid, idex, idb, exb, flush, start;
  } exp_t;

  bit     m_md;
  int     m_w;
  bit     m_tmo;
  longint m_stalls;

  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit lu;
    e = '0;
    lu = hif.ID_EX_MemRead && hif.ID_EX_RegisterRd != 0
      && ((hif.IF_ID_UsesRs1
           && hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRs1)
       || (hif.IF_ID_UsesRs2
           && hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRs2));
    if (!rst_n) return e;
    e.pc = 1; e.ifid = 1; e.idex = 1;
    if (m_md && hif.md_done) return e;
    if (m_md || hif.ID_EX_IsMulDiv) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exb = 1;
      e.start = !m_md;
    end else if (hif.branch_taken) begin
      e.flush = 1; e.idb = 1;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.idb = 1;
    end
    return e;
  endfunction

  // Reference model state advance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_md = 0; m_w = 0; m_tmo = 0; m_stalls = 0;
    end else begin
      exp_t e;
      e = model_out();
      if (!e.pc) m_stalls++;
      if (!m_md) begin
        if (hif.ID_EX_IsMulDiv) begin
          m_md = 1; m_w = 0;
        end
      end else if (hif.md_done) begin
        m_md = 0;
      end else begin
        m_w++;
        if (m_w >= MDTO) m_tmo = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    exp_t e;
    longint es;
    e  = model_out();
    es = (m_stalls > SATMAX) ? SATMAX : m_stalls;
    chk("PCWrite", hif.PCWrite, e.pc);
    chk("IF_ID_Write", hif.IF_ID_Write, e.ifid);
    chk("ID_EX_Write", hif.ID_EX_Write, e.idex);
    chk("ID_EX_Bubble", hif.ID_EX_Bubble, e.idb);
    chk("EX_MEM_Bubble", hif.EX_MEM_Bubble, e.exb);
    chk("IF_ID_Flush", hif.IF_ID_Flush, e.flush);
    chk("md_start", hif.md_start, e.start);
    chk("md_timeout", hif.md_timeout, m_tmo);
    chk("stall_cycles", hif.stall_cycles, es);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.IF_ID_RegisterRs1 = 0;
    hif.IF_ID_RegisterRs2 = 0;
    hif.IF_ID_UsesRs1     = 0;
    hif.IF_ID_UsesRs2     = 0;
    hif.ID_EX_MemRead     = 0;
    hif.ID_EX_RegisterRd  = 0;
    hif.ID_EX_IsMulDiv    = 0;
    hif.md_done           = 0;
    hif.branch_taken      = 0;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 0;
    clr();
    nxt();
    rst_n = 1;
  endtask

  task automatic set_lu(logic [4:0] rd);
    hif.ID_EX_MemRead     = 1;
    hif.ID_EX_RegisterRd  = rd;
    hif.IF_ID_RegisterRs2 = 5;
    hif.IF_ID_UsesRs2     = 1;
  endtask

  initial begin
    clr();
    rst_n = 0;
    @(negedge clk);
    chk("rst_pc", hif.PCWrite, 0);
    chk("rst_start", hif.md_start, 0);
    chk("rst_cnt", hif.stall_cycles, 0);
    chk("rst_tmo", hif.md_timeout, 0);
    nxt();
    rst_n = 1;

    // Load-use, then the same with Rd=0.
    set_lu(5);
    @(negedge clk);
    chk("lu_pc", hif.PCWrite, 0);
    chk("lu_ifid", hif.IF_ID_Write, 0);
    chk("lu_bub", hif.ID_EX_Bubble, 1);
    nxt();
    clr();
    @(negedge clk);
    chk("lu_one_pc", hif.PCWrite, 1);
    chk("lu_cnt", hif.stall_cycles, 1);
    nxt();
    set_lu(0);
    hif.IF_ID_RegisterRs2 = 0;
    @(negedge clk);
    chk("rd0_pc", hif.PCWrite, 1);
    chk("rd0_bub", hif.ID_EX_Bubble, 0);

    // Branch wins over load-use.
    nxt();
    clr();
    set_lu(5);
    hif.branch_taken = 1;
    @(negedge clk);
    chk("br_flush", hif.IF_ID_Flush, 1);
    chk("br_bub", hif.ID_EX_Bubble, 1);
    chk("br_pc", hif.PCWrite, 1);

    // Mul/div, done 3 cycles after start.
    nxt();
    clr();
    hif.ID_EX_IsMulDiv = 1;
    hif.branch_taken   = 1;
    @(negedge clk);
    chk("md_start0", hif.md_start, 1);
    chk("md_flush0", hif.IF_ID_Flush, 0);
    chk("md_pc0", hif.PCWrite, 0);
    hif.branch_taken = 0;
    for (int i = 1; i < 3; i++) begin
      nxt();
      @(negedge clk);
      chk("md_startN", hif.md_start, 0);
      chk("md_pcN", hif.PCWrite, 0);
    end
    nxt();
    hif.md_done = 1;
    @(negedge clk);
    chk("md_rel_pc", hif.PCWrite, 1);
    chk("md_rel_exb", hif.EX_MEM_Bubble, 0);
    nxt();
    clr();
    @(negedge clk);
    chk("md_run_pc", hif.PCWrite, 1);
    chk("md_cnt", hif.stall_cycles, 4);

    // Timeout, then reset abandons the op.
    nxt();
    hif.ID_EX_IsMulDiv = 1;
    repeat (64) nxt();
    @(negedge clk);
    chk("tmo_early", hif.md_timeout, 0);
    nxt();
    @(negedge clk);
    chk("tmo_set", hif.md_timeout, 1);
    chk("tmo_frz", hif.PCWrite, 0);
    hif.branch_taken = 1;
    repeat (5) nxt();
    @(negedge clk);
    chk("tmo_hold", hif.md_timeout, 1);
    chk("tmo_frz2", hif.EX_MEM_Bubble, 1);
    hif.branch_taken = 0;
    nxt();
    rst_n = 0;
    @(negedge clk);
    chk("tmo_rst", hif.md_timeout, 0);
    chk("tmo_rst_st", hif.md_start, 0);
    nxt();
    rst_n = 1;
    @(negedge clk);
    chk("tmo_restart", hif.md_start, 1);
    nxt();
    hif.md_done = 1;
    nxt();
    clr();

    // Saturation of the stall counter.
    do_reset();
    set_lu(5);
    repeat ((1 << CW) + 5) nxt();
    @(negedge clk);
    chk("sat_cnt", hif.stall_cycles, SATMAX);
    chk("sat_pc", hif.PCWrite, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      nxt();
      rst_n = ($urandom_range(0, 255) != 0);
      hif.IF_ID_RegisterRs1 = 5'($urandom_range(0, 3));
      hif.IF_ID_RegisterRs2 = 5'($urandom_range(0, 3));
      hif.IF_ID_UsesRs1     = 1'($urandom);
      hif.IF_ID_UsesRs2     = 1'($urandom);
      hif.ID_EX_MemRead     = 1'($urandom);
      hif.ID_EX_RegisterRd  = 5'($urandom_range(0, 3));
      hif.ID_EX_IsMulDiv    = ($urandom_range(0, 7) == 0);
      hif.md_done           = ($urandom_range(0, 2) == 0);
      hif.branch_taken      = ($urandom_range(0, 5) == 0);
    end
    nxt();
    rst_n = 1;
    clr();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
